// File: rtl/br_pkg.sv
// br_pkg: shared definitions for the conditional-branch sequencer.
//   state_e : sequencer state encoding (IDLE 0, EVAL 1, ADDR 2, SUM 3, WB 4)
//   cond_e  : branch condition select carried in the c2 field
package br_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EVAL = 3'd1,
      ADDR = 3'd2,
      SUM  = 3'd3,
      WB   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      COND_ZERO    = 2'b00,
      COND_NONZERO = 2'b01,
      COND_POS     = 2'b10,
      COND_NEG     = 2'b11
   } cond_e;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch-condition evaluator.
// Ports:
//   c2   in  2       condition select (zero / nonzero / positive / negative)
//   bus  in  DATA_W  register value under test (Ra)
//   flag out 1       condition result
module branch_cond
   import br_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        c2,
   input  logic [DATA_W-1:0] bus,
   output logic              flag
);

   always_comb begin
      flag = 1'b0;
      case (c2)
         COND_ZERO:    flag = (bus == '0);
         COND_NONZERO: flag = (bus != '0);
         // zero has a clear sign bit, so it counts as positive
         COND_POS:     flag = ~bus[DATA_W-1];
         COND_NEG:     flag = bus[DATA_W-1];
         default:      flag = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: micro-sequencer for conditional-branch instructions.
// Optional feature macro: BR_STATS_EN (taken / not-taken saturating counters;
// when undefined the counter ports are tied to 0 and no counter flops exist).
// Ports:
//   clk, clr (async active-high reset)
//   start, c2_field, bus, hold            inputs from control unit / datapath
//   ready                                 high in IDLE
//   r_out, con_in, pc_out, y_in, c_out,
//   alu_add, z_in, z_low_out, pc_in       datapath strobes
//   con_out                               latched condition result
//   done                                  one-cycle completion pulse (WB)
//   taken_cnt, nottaken_cnt               branch statistics
//
// state | meaning
// IDLE  | waiting for start; ready high
// EVAL  | Ra on bus, condition latched into CON
// ADDR  | PC on bus into Y
// SUM   | offset on bus, ALU add, result into Z
// WB    | done; Z into PC if branch taken
module branch_ctrl
   import br_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [1:0]        c2_field,
   input  logic [DATA_W-1:0] bus,
   input  logic              hold,
   output logic              ready,
   output logic              r_out,
   output logic              con_in,
   output logic              pc_out,
   output logic              y_in,
   output logic              c_out,
   output logic              alu_add,
   output logic              z_in,
   output logic              z_low_out,
   output logic              pc_in,
   output logic              con_out,
   output logic              done,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  nottaken_cnt
);

   state_e     state_q;
   logic [1:0] c2_q;
   logic       con_q;
   logic       cond_flag;

   branch_cond #(.DATA_W(DATA_W)) u_cond (
      .c2   (c2_q),
      .bus  (bus),
      .flag (cond_flag)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         c2_q    <= 2'b00;
         con_q   <= 1'b0;
      end else if (!hold) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= EVAL;
                  c2_q    <= c2_field;
               end
            end
            EVAL: begin
               con_q   <= cond_flag;
               state_q <= cond_flag ? ADDR : WB;
            end
            ADDR:    state_q <= SUM;
            SUM:     state_q <= WB;
            WB:      state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes decode only from registered state and hold, so an async clr
   // (state forced to IDLE) drops every strobe in the same cycle.
   always_comb begin
      r_out     = 1'b0;
      con_in    = 1'b0;
      pc_out    = 1'b0;
      y_in      = 1'b0;
      c_out     = 1'b0;
      alu_add   = 1'b0;
      z_in      = 1'b0;
      z_low_out = 1'b0;
      pc_in     = 1'b0;
      done      = 1'b0;
      if (!hold) begin
         case (state_q)
            EVAL: begin
               r_out  = 1'b1;
               con_in = 1'b1;
            end
            ADDR: begin
               pc_out = 1'b1;
               y_in   = 1'b1;
            end
            SUM: begin
               c_out   = 1'b1;
               alu_add = 1'b1;
               z_in    = 1'b1;
            end
            WB: begin
               done      = 1'b1;
               z_low_out = con_q;
               pc_in     = con_q;
            end
            default: ;
         endcase
      end
   end

   assign ready   = (state_q == IDLE);
   assign con_out = con_q;

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] taken_q;
   logic [CNT_W-1:0] nottaken_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         taken_q    <= '0;
         nottaken_q <= '0;
      end else if (!hold && state_q == WB) begin
         if (con_q) begin
            if (taken_q != '1) taken_q <= taken_q + CNT_W'(1);
         end else begin
            if (nottaken_q != '1) nottaken_q <= nottaken_q + CNT_W'(1);
         end
      end
   end

   assign taken_cnt    = taken_q;
   assign nottaken_cnt = nottaken_q;
`else
   assign taken_cnt    = '0;
   assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 2;

   // strobe vector order: r_out con_in pc_out y_in c_out alu_add z_in z_low_out pc_in done
   localparam logic [9:0] S_IDLE = 10'b00_00_000_000;
   localparam logic [9:0] S_EVAL = 10'b11_00_000_000;
   localparam logic [9:0] S_ADDR = 10'b00_11_000_000;
   localparam logic [9:0] S_SUM  = 10'b00_00_111_000;
   localparam logic [9:0] S_WBT  = 10'b00_00_000_111;
   localparam logic [9:0] S_WBN  = 10'b00_00_000_001;

   logic              clk = 1'b0;
   logic              clr;
   logic              start;
   logic [1:0]        c2_field;
   logic [DATA_W-1:0] bus;
   logic              hold;
   logic              ready, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in;
   logic              z_low_out, pc_in, con_out, done;
   logic [CNT_W-1:0]  taken_cnt, nottaken_cnt;
   logic [9:0]        strb;

   int n_assert = 0;
   int n_fail   = 0;
   int m_taken  = 0;
   int m_ntaken = 0;

   always #5 clk = ~clk;

   branch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .start(start), .c2_field(c2_field), .bus(bus), .hold(hold),
      .ready(ready), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
      .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .z_low_out(z_low_out),
      .pc_in(pc_in), .con_out(con_out), .done(done),
      .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
   );

   assign strb = {r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, z_low_out, pc_in, done};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
   endfunction

   task automatic chk_cnt(input string tag);
`ifdef BR_STATS_EN
      chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(sat(m_taken)));
      chk({tag, "_nottaken_cnt"}, 32'(nottaken_cnt), 32'(sat(m_ntaken)));
`else
      chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'd0);
      chk({tag, "_nottaken_cnt"}, 32'(nottaken_cnt), 32'd0);
`endif
   endtask

   // Full branch with no hold; c2_field is scrambled after the accept edge
   // to confirm the captured copy is what gets evaluated.
   task automatic run_branch(input string tag, input logic [1:0] c2, input logic [31:0] bv,
                             input bit exp_taken);
      start = 1'b1; c2_field = c2;
      tick();
      start = 1'b0; c2_field = ~c2; bus = bv;
      #1;
      chk({tag, "_eval_strb"}, 32'(strb), 32'(S_EVAL));
      chk({tag, "_eval_ready"}, 32'(ready), 32'd0);
      tick();
      bus = 32'hA5A5_5A5A;
      if (exp_taken) begin
         chk({tag, "_addr_strb"}, 32'(strb), 32'(S_ADDR));
         tick();
         chk({tag, "_sum_strb"}, 32'(strb), 32'(S_SUM));
         tick();
      end
      chk({tag, "_wb_strb"}, 32'(strb), 32'(exp_taken ? S_WBT : S_WBN));
      chk({tag, "_con_out"}, 32'(con_out), 32'(exp_taken));
      if (exp_taken) m_taken++; else m_ntaken++;
      tick();
      chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
      chk({tag, "_idle_strb"}, 32'(strb), 32'(S_IDLE));
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; c2_field = 2'b00; bus = '0; hold = 1'b0;
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_strb", 32'(strb), 32'(S_IDLE));
      chk("rst_con", 32'(con_out), 32'd0);
      chk_cnt("rst");
      clr = 1'b0;
      tick();

      run_branch("taken_zero", 2'b00, 32'h0000_0000, 1'b1);

      // async clr in ADDR after a taken branch left con_out = 1
      start = 1'b1; c2_field = 2'b00;
      tick();
      start = 1'b0; bus = 32'h0;
      tick();
      chk("clr_pre_addr", 32'(strb), 32'(S_ADDR));
      #2 clr = 1'b1;
      #1;
      chk("clr_strb", 32'(strb), 32'(S_IDLE));
      chk("clr_ready", 32'(ready), 32'd1);
      chk("clr_con", 32'(con_out), 32'd0);
      m_taken = 0; m_ntaken = 0;
      chk_cnt("clr");
      tick();
      clr = 1'b0;
      tick();

      run_branch("ntaken_neg", 2'b11, 32'h0000_0005, 1'b0);
      run_branch("pos_zero", 2'b10, 32'h0000_0000, 1'b1);
      run_branch("pos_msb", 2'b10, 32'h8000_0000, 1'b0);
      chk_cnt("mid");

      // hold in IDLE: start ignored
      hold = 1'b1; start = 1'b1; c2_field = 2'b00;
      tick();
      chk("hold_idle_ready", 32'(ready), 32'd1);
      chk("hold_idle_strb", 32'(strb), 32'(S_IDLE));
      start = 1'b0; hold = 1'b0;
      tick();
      chk("hold_idle_after", 32'(ready), 32'd1);

      // taken branch held 3 cycles in SUM; start during ADDR is ignored
      start = 1'b1; c2_field = 2'b00;
      tick();
      start = 1'b0; bus = 32'h0;
      tick();                                   // cycle 2: ADDR
      chk("hs_addr", 32'(strb), 32'(S_ADDR));
      start = 1'b1; c2_field = 2'b01;
      tick();                                   // cycle 3: SUM
      start = 1'b0;
      chk("hs_sum", 32'(strb), 32'(S_SUM));
      hold = 1'b1;
      #1;
      chk("hs_hold1_strb", 32'(strb), 32'(S_IDLE));
      chk("hs_hold1_ready", 32'(ready), 32'd0);
      tick();                                   // cycle 4
      chk("hs_hold2_strb", 32'(strb), 32'(S_IDLE));
      tick();                                   // cycle 5
      chk("hs_hold3_strb", 32'(strb), 32'(S_IDLE));
      chk("hs_hold3_con", 32'(con_out), 32'd1);
      tick();                                   // cycle 6: released, SUM again
      hold = 1'b0;
      #1;
      chk("hs_sum_again", 32'(strb), 32'(S_SUM));
      tick();                                   // cycle 7: WB
      chk("hs_wb", 32'(strb), 32'(S_WBT));
      m_taken++;
      tick();
      chk("hs_idle", 32'(ready), 32'd1);

      run_branch("loop_nonzero", 2'b01, 32'h0000_1234, 1'b1);
      run_branch("loop_neg", 2'b11, 32'h8000_0001, 1'b1);
      run_branch("loop_pos", 2'b10, 32'h7FFF_FFFF, 1'b1);

      // start held through WB is not accepted until the first IDLE cycle
      start = 1'b1; c2_field = 2'b01;
      tick();
      bus = 32'h0000_0001;
      tick(); tick(); tick();
      chk("wbs_wb", 32'(strb), 32'(S_WBT));
      m_taken++;
      bus = 32'h0;
      tick();
      chk("wbs_idle_ready", 32'(ready), 32'd1);
      chk("wbs_idle_strb", 32'(strb), 32'(S_IDLE));
      tick();
      start = 1'b0;
      chk("wbs_eval", 32'(strb), 32'(S_EVAL));
      tick();
      chk("wbs_wb2", 32'(strb), 32'(S_WBN));
      m_ntaken++;
      tick();
      chk("wbs_end", 32'(ready), 32'd1);

      chk_cnt("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencer for conditional-branch instructions in the CPU datapath. On a `start` pulse it runs the bus and register strobes for the branch micro-sequence:

- drive Ra onto the bus and latch the condition (CON);
- if the branch is taken, compute PC + offset through Y/ALU/Z;
- load PC from Z when taken.

It sits beside the main control unit, which hands over branch opcodes and waits for `done`.

## Interface
Parameters:
- DATA_W, 32, bus width
- CNT_W, 16, statistics counter width (used only with BR_STATS_EN)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- start  in  1  branch issue pulse; accepted only in IDLE
- c2_field  in  2  condition select, sampled with start: 00 zero, 01 nonzero, 10 positive, 11 negative
- bus  in  DATA_W  shared bus, carrying Ra during EVAL
- hold  in  1  stall; freezes the sequence
- ready  out  1  high in IDLE
- r_out  out  1  gate Ra onto bus
- con_in  out  1  strobe CON latch
- pc_out  out  1  gate PC onto bus
- y_in  out  1  load Y
- c_out  out  1  gate sign-extended offset onto bus
- alu_add  out  1  ALU add select
- z_in  out  1  load Z
- z_low_out  out  1  gate Z low onto bus
- pc_in  out  1  load PC
- con_out  out  1  latched condition result
- done  out  1  one-cycle completion pulse
- taken_cnt  out  CNT_W  taken-branch count
- nottaken_cnt  out  CNT_W  not-taken-branch count

## Operation
- States: IDLE, EVAL, ADDR, SUM, WB.
- Transitions:
  - IDLE→EVAL on start; c2_field is captured into an internal register at the same edge.
  - EVAL→ADDR if the evaluated condition is true, else EVAL→WB.
  - ADDR→SUM→WB.
  - WB→IDLE.
- Condition is evaluated combinationally from the captured c2 and bus:
  - zero: bus == 0
  - nonzero: bus != 0
  - positive: bus[DATA_W-1] == 0; zero counts as positive
  - negative: bus[DATA_W-1] == 1
- Strobes asserted per state:
  - EVAL: r_out, con_in.
  - ADDR: pc_out, y_in.
  - SUM: c_out, alu_add, z_in.
  - WB: done. Also z_low_out and pc_in when con_out = 1.
  - IDLE: no strobes.
- con_out is registered at the EVAL→next edge and holds until the next EVAL or reset.
- hold = 1:
  - state and con_out are frozen;
  - all strobes and done are forced to 0;
  - `start` is ignored; ready stays at its state-based value.
  - The sequence resumes in the same state once hold = 0.
- start outside IDLE: ignored, with no queuing.

## Timing
- Reset values:
  - state IDLE, ready 1;
  - every strobe 0, con_out 0, done 0;
  - counters 0.
- clr is asynchronous. Mid-sequence clr aborts immediately and all strobes drop in the same cycle. No partial PC load is permitted.
- Latency from the start edge to the done cycle, with no hold:
  - taken: 4 cycles (EVAL, ADDR, SUM, WB);
  - not taken: 2 cycles (EVAL, WB).
- Strobes are Moore outputs. Decode them from the registered state and hold only; never from start.
- A start in the same cycle that WB→IDLE occurs is not accepted. The earliest new accept is the first IDLE cycle, so at least one ready cycle separates branches.

## Configuration
- BR_STATS_EN defined:
  - taken_cnt increments in WB when con_out = 1; nottaken_cnt increments when con_out = 0.
  - Both counters saturate at all-ones.
  - clr clears both counters.
- BR_STATS_EN undefined: ports remain and are tied to 0; no counter flops are synthesized.

## Structure
- Shared package br_pkg holds:
  - state encoding constants: IDLE 0, EVAL 1, ADDR 2, SUM 3, WB 4;
  - condition codes: COND_ZERO, COND_NONZERO, COND_POS, COND_NEG.
- Sub-module branch_cond:
  - purely combinational;
  - inputs: c2 and bus; output: flag.
  - It is instantiated once in branch_ctrl.

## Test plan
- Taken zero: c2 = 00, bus = 0x00000000 in EVAL → ADDR, SUM, WB follow; pc_in = 1 in WB; con_out = 1; done 4 cycles after start.
- Not-taken negative: c2 = 11, bus = 0x00000005 → EVAL→WB; pc_in = 0; done 2 cycles after start; con_out = 0.
- Positive boundary: c2 = 10, bus = 0x00000000 → taken. c2 = 10, bus = 0x80000000 → not taken.
- Hold in SUM for 3 cycles: all strobes are 0 during the hold; SUM strobes reassert after release; total taken latency is 7 cycles.
- clr asserted in ADDR: same cycle shows pc_out = 0, y_in = 0, ready = 1, con_out = 0; a later start runs normally.
- BR_STATS_EN with CNT_W = 2: 5 taken branches → taken_cnt = 3 (saturated), nottaken_cnt = 0. Without the macro, both counters read 0.
